// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StDone
  } rx_state_e;

  // Bit index of the start bit within a frame.
  localparam int unsigned START_BIT_IDX = 0;

  // Offset past mid-bit where the oversampled value is considered stable.
  localparam int unsigned CHK_OFFSET = 2;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter and bit counter for the UART receiver.
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_WIDTH = 6,
  parameter int unsigned BIT_CNT_WIDTH  = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic                      clr_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt_o,
  output logic [BIT_CNT_WIDTH-1:0]  bit_cnt_o,
  output logic                      edge_last_o
);

  logic [PRESCALE_WIDTH-1:0] edge_q, edge_d;
  logic [BIT_CNT_WIDTH-1:0]  bit_q, bit_d;
  logic [PRESCALE_WIDTH-1:0] last;

  assign last        = prescale_i - PRESCALE_WIDTH'(1);
  assign edge_last_o = (edge_q == last);
  assign edge_cnt_o  = edge_q;
  assign bit_cnt_o   = bit_q;

  // Next count: clear wins over enable; edge wraps at LAST and advances the bit index.
  always_comb begin
    edge_d = edge_q;
    bit_d  = bit_q;
    if (clr_i) begin
      edge_d = '0;
      bit_d  = BIT_CNT_WIDTH'(START_BIT_IDX);
    end else if (en_i) begin
      if (edge_last_o) begin
        edge_d = '0;
        bit_d  = bit_q + BIT_CNT_WIDTH'(1);
      end else begin
        edge_d = edge_q + PRESCALE_WIDTH'(1);
      end
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detection, bit-period stepping, checker strobes, frame verdict.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 6,
  parameter int unsigned BIT_CNT_WIDTH  = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      strt_glitch,
  input  logic                      par_err,
  input  logic                      stp_err,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [BIT_CNT_WIDTH-1:0]  bit_cnt,
  output logic                      dat_samp_en,
  output logic                      deser_en,
  output logic                      strt_chk_en,
  output logic                      par_chk_en,
  output logic                      stp_chk_en,
  output logic                      data_valid,
  output logic                      frame_err
);

  rx_state_e state_q, state_d;
  logic      par_en_q, par_en_d;
  logic      bad_q, bad_d;
  logic      cnt_en, cnt_clr, edge_last;
  logic      past_chk;
  logic [PRESCALE_WIDTH-1:0] chk;

  assign chk      = (Prescale >> 1) + PRESCALE_WIDTH'(CHK_OFFSET);
  assign past_chk = (edge_cnt >= chk);

  uart_rx_edge_bit_cnt #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH),
    .BIT_CNT_WIDTH (BIT_CNT_WIDTH)
  ) u_cnt (
    .clk_i      (CLK),
    .rst_i      (RST),
    .en_i       (cnt_en),
    .clr_i      (cnt_clr),
    .prescale_i (Prescale),
    .edge_cnt_o (edge_cnt),
    .bit_cnt_o  (bit_cnt),
    .edge_last_o(edge_last)
  );

  // Next-state, counter control and strobe decode.
  always_comb begin
    state_d     = state_q;
    par_en_d    = par_en_q;
    bad_d       = bad_q;
    cnt_en      = 1'b0;
    cnt_clr     = 1'b0;
    dat_samp_en = 1'b0;
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    data_valid  = 1'b0;
    frame_err   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_clr = 1'b1;
        if (!RX_IN) begin
          state_d  = StStart;
          par_en_d = PAR_EN;
          bad_d    = 1'b0;
        end
      end
      StStart: begin
        cnt_en      = 1'b1;
        dat_samp_en = 1'b1;
        strt_chk_en = past_chk;
        if (edge_last) begin
          if (strt_glitch) begin
            state_d = StIdle;
            cnt_clr = 1'b1;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        cnt_en      = 1'b1;
        dat_samp_en = 1'b1;
        deser_en    = (edge_cnt == chk);
        if (edge_last && (bit_cnt == BIT_CNT_WIDTH'(DATA_WIDTH))) begin
          state_d = par_en_q ? StParity : StStop;
        end
      end
      StParity: begin
        cnt_en      = 1'b1;
        dat_samp_en = 1'b1;
        par_chk_en  = past_chk;
        if (edge_last) begin
          state_d = StStop;
          if (par_err) bad_d = 1'b1;
        end
      end
      StStop: begin
        cnt_en      = 1'b1;
        dat_samp_en = 1'b1;
        stp_chk_en  = past_chk;
        if (edge_last) begin
          state_d = StDone;
          cnt_clr = 1'b1;
          if (stp_err) bad_d = 1'b1;
        end
      end
      StDone: begin
        cnt_clr    = 1'b1;
        data_valid = !bad_q;
        frame_err  = bad_q;
        bad_d      = 1'b0;
        // A low line here is the next start bit; skip IDLE for back-to-back frames.
        if (!RX_IN) begin
          state_d  = StStart;
          par_en_d = PAR_EN;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // State, captured parity enable and sticky error flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      par_en_q <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      par_en_q <= par_en_d;
      bad_q    <= bad_d;
    end
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-path sequencer for the UART RX.
- Detects the start bit and maintains the oversampling edge and bit counters.
- Steps through the START, DATA, PARITY and STOP bit periods, driving the enable strobes for the sampler, deserializer, start/parity/stop checkers.
- Collects checker error flags and issues a single-cycle data_valid for each good frame. Sits between RX_IN and the RX datapath blocks.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- PRESCALE_WIDTH, 6, width of the Prescale input and edge counter.
- BIT_CNT_WIDTH, 4, width of the bit counter; must hold DATA_WIDTH+2.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- RX_IN  in  1  serial line, idle high.
- PAR_EN  in  1  parity bit present in frame.
- Prescale  in  PRESCALE_WIDTH  oversampling ratio; supported values 16 and 32.
- strt_glitch  in  1  start checker result.
- par_err  in  1  parity checker result.
- stp_err  in  1  stop checker result.
- edge_cnt  out  PRESCALE_WIDTH  oversample edge index within the current bit.
- bit_cnt  out  BIT_CNT_WIDTH  current bit index; 0 is the start bit.
- dat_samp_en  out  1  sampler enable.
- deser_en  out  1  deserializer shift strobe.
- strt_chk_en  out  1  start checker enable.
- par_chk_en  out  1  parity checker enable.
- stp_chk_en  out  1  stop checker enable.
- data_valid  out  1  frame accepted; one-cycle pulse.
- frame_err  out  1  frame rejected; one-cycle pulse.

Behaviour:
- Reset:
  - Synchronous: RST high at a CLK edge forces state IDLE and clears all counters and outputs at that edge.
  - Applies mid-frame too; the partial frame is dropped with no data_valid or frame_err.
- Definitions:
  - LAST = Prescale-1.
  - CHK = Prescale/2+2, the first edge at which the sampled bit is stable.
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE:
  - Counters held at 0.
  - RX_IN==0 sampled at cycle T moves to START at T+1 with edge_cnt=0 and bit_cnt=0.
  - PAR_EN is captured at T; changes mid-frame are ignored.
- Counters:
  - In any non-IDLE bit state, edge_cnt increments each cycle.
  - At edge_cnt==LAST, edge_cnt wraps to 0 and bit_cnt increments.
- dat_samp_en: high in START, DATA, PARITY and STOP; low in IDLE and DONE.
- Check enables: strt_chk_en, par_chk_en and stp_chk_en are each held high in their own state from edge_cnt==CHK through edge_cnt==LAST inclusive.
- Error capture: the corresponding error input is sampled at edge_cnt==LAST of that bit.
- deser_en: one-cycle pulse in DATA at edge_cnt==CHK, once per data bit, LSB first.
- Transitions, all taken at edge_cnt==LAST:
  - START with strt_glitch=1 goes to IDLE. No data_valid and no frame_err; counters cleared.
  - START with strt_glitch=0 goes to DATA.
  - DATA at bit_cnt==DATA_WIDTH goes to PARITY if the captured PAR_EN is 1, otherwise STOP.
  - PARITY goes to STOP. par_err=1 sets a sticky bad flag.
  - STOP goes to DONE. stp_err=1 sets the bad flag.
- DONE (one cycle):
  - data_valid=1 if the bad flag is clear, else frame_err=1.
  - The bad flag is then cleared.
  - Next state is START (edge_cnt=0, bit_cnt=0) if RX_IN==0 in DONE, otherwise IDLE. This allows back-to-back frames.
- Latency (Prescale=16, DATA_WIDTH=8):
  - Without parity, data_valid at T+161.
  - With parity, data_valid at T+177.
- data_valid and frame_err are never both high.
- Unsupported Prescale values give undefined timing; no checking is done.

Decomposition:
- Package uart_rx_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP, DONE);
  - START_BIT_IDX = 0;
  - CHK offset constant (+2).
- Sub-module uart_rx_edge_bit_cnt: edge and bit counters with enable, clear and Prescale inputs. It reports edge_last, i.e. edge_cnt==LAST. The FSM instantiates it.

Test Plan:
- Prescale=16, PAR_EN=0, frame 0xA5 with good stop: deser_en pulses exactly 8 times at edge 10, data_valid=1 at T+161 only, frame_err never high.
- Prescale=16, PAR_EN=1, 0x3C, par_err held high through the parity bit: par_chk_en high edges 10–15 of bit 9, frame_err=1 at T+177, data_valid stays 0.
- Start glitch (RX_IN low for 4 cycles, strt_glitch=1 at edge 15): state IDLE at T+17, no deser_en, no data_valid or frame_err.
- Back-to-back frames, 0x01 then 0xFE, with RX_IN low in the DONE cycle: second START entered with no IDLE cycle, two data_valid pulses 161 cycles apart.
- Prescale=32, PAR_EN=0, stp_err=1: stp_chk_en high edges 18–31 of bit 9, frame_err=1 at T+321.
- RST asserted at bit_cnt=4 mid-frame: next cycle all outputs 0 and state IDLE. A following good frame 0x55 produces data_valid normally.
